// File: rtl/registradores.sv
// registradores: 8 x 8-bit general-purpose register file.
// Two combinational read ports feed the ALU operands; one clocked write port
// serves writeback. Reset is synchronous and clears every register.
module registradores #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] reg1,
  input  logic [ADDR_WIDTH-1:0] reg2,
  input  logic [ADDR_WIDTH-1:0] regE,
  input  logic [DATA_WIDTH-1:0] EscData,
  input  logic                  escrita,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Storage update: reset wins over a same-cycle write; otherwise write one register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (escrita) begin
      r_regs[regE] <= EscData;
    end
  end

  // Read ports: no write-through bypass, forwarding is left to the pipeline.
  assign out1 = r_regs[reg1];
  assign out2 = r_regs[reg2];

endmodule

// File: tb/tb_registradores.sv
// tb_registradores: directed plus randomized checks of the register file
// against an array-based reference model.
module tb_registradores;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  logic          clock;
  logic          reset;
  logic [AW-1:0] reg1;
  logic [AW-1:0] reg2;
  logic [AW-1:0] regE;
  logic [DW-1:0] EscData;
  logic          escrita;
  logic [DW-1:0] out1;
  logic [DW-1:0] out2;

  int checks;
  int failures;

  logic [DW-1:0] model [NR];

  registradores #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock  (clock),
    .reset  (reset),
    .reg1   (reg1),
    .reg2   (reg2),
    .regE   (regE),
    .EscData(EscData),
    .escrita(escrita),
    .out1   (out1),
    .out2   (out2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Update the model from the inputs present at this edge, then let the edge happen.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < int'(NR); i++) model[i] = '0;
    end else if (escrita) begin
      model[int'(regE)] = EscData;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input int a, input logic [DW-1:0] d);
    reset   = 1'b0;
    escrita = 1'b1;
    regE    = AW'(a);
    EscData = d;
    tick();
    escrita = 1'b0;
  endtask

  // Read every register through both ports and compare with the model.
  task automatic sweep(input string tag);
    for (int i = 0; i < int'(NR); i++) begin
      reg1 = AW'(i);
      reg2 = AW'(NR - 1 - i);
      #1;
      check($sformatf("%s_out1_r%0d", tag, i), out1, model[i]);
      check($sformatf("%s_out2_r%0d", tag, NR - 1 - i), out2, model[NR-1-i]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < int'(NR); i++) model[i] = 'x;
    reset = 1'b1; escrita = 1'b0; regE = '0; EscData = '0; reg1 = '0; reg2 = '0;
    @(negedge clock);

    // Initial reset
    tick();
    sweep("init_reset");

    // Reset clears and overrides a same-cycle write
    for (int i = 0; i < int'(NR); i++) write_reg(i, 8'hFF);
    sweep("all_ff");
    reset = 1'b1; escrita = 1'b1; regE = 3'd0; EscData = 8'h43;
    tick();
    reset = 1'b0; escrita = 1'b0;
    sweep("reset_clear");

    // Basic write/read on r0
    write_reg(0, 8'h01);
    reg1 = 3'd0; reg2 = 3'd0; #1;
    check("basic_out1", out1, 8'h01);
    check("basic_out2", out2, 8'h01);
    write_reg(0, 8'h43);
    #1;
    check("basic_43", out1, 8'h43);

    // Write enable gating
    escrita = 1'b0; regE = 3'd3; EscData = 8'hAA;
    repeat (3) tick();
    reg1 = 3'd3; #1;
    check("gated_r3", out1, 8'h00);

    // Dual read and combinational swap
    for (int i = 0; i < int'(NR); i++) write_reg(i, DW'(8'h10 + i));
    reg1 = 3'd2; reg2 = 3'd7; #1;
    check("dual_out1", out1, 8'h12);
    check("dual_out2", out2, 8'h17);
    reg1 = 3'd7; reg2 = 3'd2; #1;
    check("swap_out1", out1, 8'h17);
    check("swap_out2", out2, 8'h12);

    // Read during write: old value before the edge, new after
    reg1 = 3'd5; regE = 3'd5; EscData = 8'h99; escrita = 1'b1; #1;
    check("rdw_before", out1, 8'h15);
    tick();
    escrita = 1'b0;
    check("rdw_after", out1, 8'h99);

    // Reset held for several edges while writes are attempted
    reset = 1'b1; escrita = 1'b1;
    for (int k = 0; k < 4; k++) begin
      regE    = AW'($urandom_range(0, NR - 1));
      EscData = DW'($urandom);
      tick();
    end
    reset = 1'b0; escrita = 1'b0;
    sweep("reset_held");
    write_reg(4, 8'h43);
    sweep("only_r4");

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      reset   = ($urandom_range(0, 29) == 0);
      escrita = $urandom_range(0, 1) == 1;
      regE    = AW'($urandom_range(0, NR - 1));
      EscData = DW'($urandom);
      reg1    = AW'($urandom_range(0, NR - 1));
      reg2    = AW'($urandom_range(0, NR - 1));
      #1;
      check("rand_pre_out1", out1, model[int'(reg1)]);
      check("rand_pre_out2", out2, model[int'(reg2)]);
      tick();
      check("rand_post_out1", out1, model[int'(reg1)]);
      check("rand_post_out2", out2, model[int'(reg2)]);
    end
    reset = 1'b0; escrita = 1'b0;
    sweep("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
